// File: rtl/pc_exc_unit.sv
// pc_exc_unit: program counter register with branch qualification and exception entry
// that saves EPC and loads PC from a byte fetched at a fixed vector address.
module pc_exc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] VEC_OPCODE  = 32'd253,
  parameter logic [31:0] VEC_OVF     = 32'd254,
  parameter logic [31:0] VEC_DIV     = 32'd255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_next_i,
  input  logic        pc_write_i,
  input  logic        pc_write_cond_i,
  input  logic [1:0]  branch_type_i,
  input  logic        alu_zero_i,
  input  logic        alu_gt_i,
  input  logic        exc_opcode_i,
  input  logic        exc_overflow_i,
  input  logic        exc_divzero_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] epc_o,
  output logic [1:0]  exc_cause_o,
  output logic        mem_rd_req_o,
  output logic [31:0] mem_addr_o,
  output logic        exc_busy_o
);
  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, LOAD} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        cond, take, exc_any;
  logic        unused_hi;
  assign unused_hi = ^mem_rdata_i[31:8];
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end
  always_comb begin
    cond    = branch_type_i[1] ? (branch_type_i[0] ? alu_gt_i : !alu_gt_i)
                               : (branch_type_i[0] ? !alu_zero_i : alu_zero_i);
    take    = pc_write_i | (pc_write_cond_i & cond);
    exc_any = exc_opcode_i | exc_overflow_i | exc_divzero_i;
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        // exception entry takes precedence over any PC load in the same cycle
        if (exc_any) begin
          cause_d = exc_opcode_i ? 2'd1 : exc_overflow_i ? 2'd2 : 2'd3;
          epc_d   = pc_q - 32'd4;
          state_d = REQ;
        end else if (take) begin
          pc_d = pc_next_i;
        end
      end
      REQ: begin
        cnt_d   = LAT_M1;
        state_d = (MEM_LATENCY == 1) ? LOAD : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? LOAD : WAIT;
      end
      LOAD: begin
        pc_d    = {24'b0, mem_rdata_i[7:0]};
        state_d = IDLE;
      end
    endcase
  end
  assign pc_o         = pc_q;
  assign epc_o        = epc_q;
  assign exc_cause_o  = cause_q;
  assign exc_busy_o   = state_q != IDLE;
  assign mem_rd_req_o = state_q == REQ;
  assign mem_addr_o   = !mem_rd_req_o ? 32'd0 :
                        cause_q == 2'd1 ? VEC_OPCODE :
                        cause_q == 2'd2 ? VEC_OVF : VEC_DIV;
endmodule

// File: tb/tb_pc_exc_unit.sv
// tb_pc_exc_unit: runs MEM_LATENCY=1 and MEM_LATENCY=3 instances side by side on shared
// stimulus and compares both against a cycle-count reference model.
module tb_pc_exc_unit;
  logic        clk, reset;
  logic [31:0] pc_next;
  logic        pc_write, pc_write_cond, alu_zero, alu_gt;
  logic [1:0]  branch_type;
  logic        exc_opcode, exc_overflow, exc_divzero;
  logic [31:0] mem_rdata [2];
  logic [31:0] pc_o [2], epc_o [2], mem_addr_o [2];
  logic [1:0]  cause_o [2];
  logic        rdreq_o [2], busy_o [2];
  logic [7:0]  vec_byte [0:3];
  logic [23:0] mem_hi;
  int          passed = 0, total = 0;
  logic [31:0] m_pc [2], m_epc [2];
  logic [1:0]  m_cause [2];
  int          m_busy [2];
  initial clk = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    int          age;
    logic [31:0] raddr;
    pc_exc_unit #(.MEM_LATENCY(L)) u_dut (
      .clk_i(clk), .reset_i(reset), .pc_next_i(pc_next), .pc_write_i(pc_write),
      .pc_write_cond_i(pc_write_cond), .branch_type_i(branch_type),
      .alu_zero_i(alu_zero), .alu_gt_i(alu_gt), .exc_opcode_i(exc_opcode),
      .exc_overflow_i(exc_overflow), .exc_divzero_i(exc_divzero),
      .mem_rdata_i(mem_rdata[g]), .pc_o(pc_o[g]), .epc_o(epc_o[g]),
      .exc_cause_o(cause_o[g]), .mem_rd_req_o(rdreq_o[g]),
      .mem_addr_o(mem_addr_o[g]), .exc_busy_o(busy_o[g]));
    // memory returns the vector byte only exactly L cycles after the request cycle
    always @(posedge clk or posedge reset)
      if (reset) begin
        age   <= 0;
        raddr <= '0;
      end else if (rdreq_o[g]) begin
        age   <= 1;
        raddr <= mem_addr_o[g];
      end else if (age != 0 && age < 8) age <= age + 1;
    assign mem_rdata[g] = {mem_hi, (age == L) ? vec_byte[raddr[1:0]] : 8'h5A};
  end
  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask
  task automatic model_reset;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'h0; m_epc[i] = 32'h0; m_cause[i] = 2'd0; m_busy[i] = 0;
    end
  endtask
  task automatic model_step;
    logic c;
    c = (branch_type == 2'd0) ? alu_zero : (branch_type == 2'd1) ? !alu_zero :
        (branch_type == 2'd2) ? !alu_gt : alu_gt;
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i] > 0) begin
        if (m_busy[i] == 1) m_pc[i] = {24'h0, vec_byte[m_cause[i]]};
        m_busy[i]--;
      end else if (exc_opcode || exc_overflow || exc_divzero) begin
        m_cause[i] = exc_opcode ? 2'd1 : exc_overflow ? 2'd2 : 2'd3;
        m_epc[i]   = m_pc[i] - 32'd4;
        m_busy[i]  = lat(i) + 1;
      end else if (pc_write || (pc_write_cond && c)) m_pc[i] = pc_next;
    end
  endtask
  task automatic check_model;
    logic req;
    for (int i = 0; i < 2; i++) begin
      req = m_busy[i] == lat(i) + 1;
      chk($sformatf("pc[%0d]", i), pc_o[i], m_pc[i]);
      chk($sformatf("epc[%0d]", i), epc_o[i], m_epc[i]);
      chk($sformatf("cause[%0d]", i), 32'(cause_o[i]), 32'(m_cause[i]));
      chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_busy[i] > 0));
      chk($sformatf("rdreq[%0d]", i), 32'(rdreq_o[i]), 32'(req));
      chk($sformatf("addr[%0d]", i), mem_addr_o[i], req ? 32'd252 + 32'(m_cause[i]) : 32'd0);
    end
  endtask
  task automatic tick;
    if (reset) model_reset();
    @(negedge clk);
    check_model();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask
  task automatic clear_in;
    pc_write = 0; pc_write_cond = 0; exc_opcode = 0; exc_overflow = 0; exc_divzero = 0;
  endtask
  initial begin
    int busy_cnt;
    logic tk;
    reset = 1; clear_in(); pc_next = '0; branch_type = '0; alu_zero = 0; alu_gt = 0;
    vec_byte[0] = 8'h00; vec_byte[1] = 8'h3C; vec_byte[2] = 8'h7C; vec_byte[3] = 8'hC8;
    mem_hi = 24'hFFFFFF;
    model_reset();
    @(posedge clk); #1;
    chk("rst_pc", pc_o[0], 32'h0);
    chk("rst_epc", epc_o[1], 32'h0);
    chk("rst_busy", 32'(busy_o[1]), 32'h0);
    reset = 0;
    pc_next = 32'h4; pc_write = 1; tick(); pc_write = 0;
    chk("write_pc", pc_o[0], 32'h4);
    pc_next = 32'h8; pc_write = 1; tick(); pc_write = 0;
    #2 reset = 1; #1;
    chk("async_rst_pc0", pc_o[0], 32'h0);
    chk("async_rst_pc1", pc_o[1], 32'h0);
    tick(); reset = 0;
    for (int bt = 0; bt < 4; bt++)
      for (int f = 0; f < 2; f++) begin
        pc_next = 32'h100; pc_write = 1; tick(); pc_write = 0;
        pc_write_cond = 1; branch_type = 2'(bt); alu_zero = f[0]; alu_gt = f[0];
        pc_next = 32'h40; tick(); pc_write_cond = 0;
        tk = ((bt == 0) || (bt == 3)) ? f[0] : !f[0];
        chk($sformatf("branch_bt%0d_f%0d", bt, f), pc_o[0], tk ? 32'h40 : 32'h100);
      end
    pc_next = 32'h20; pc_write = 1; tick(); pc_write = 0;
    exc_overflow = 1; tick(); exc_overflow = 0;
    chk("ovf_rdreq", 32'(rdreq_o[0]), 32'h1);
    chk("ovf_addr", mem_addr_o[0], 32'd254);
    chk("ovf_epc", epc_o[0], 32'h1C);
    chk("ovf_cause", 32'(cause_o[0]), 32'h2);
    tick();
    chk("ovf_rdreq_drop", 32'(rdreq_o[0]), 32'h0);
    chk("ovf_pc_hold", pc_o[0], 32'h20);
    tick();
    chk("ovf_pc_l1", pc_o[0], 32'h7C);
    tick(); tick();
    chk("ovf_pc_l3", pc_o[1], 32'h7C);
    exc_opcode = 1; exc_overflow = 1; exc_divzero = 1; pc_write = 1; pc_next = 32'h99;
    tick(); clear_in();
    chk("prio_cause", 32'(cause_o[0]), 32'h1);
    chk("prio_addr", mem_addr_o[1], 32'd253);
    chk("prio_no_load", pc_o[0], 32'h7C);
    repeat (4) tick();
    chk("prio_pc0", pc_o[0], 32'h3C);
    chk("prio_pc1", pc_o[1], 32'h3C);
    exc_divzero = 1; tick(); exc_divzero = 0;
    busy_cnt = 0;
    pc_next = 32'h55;
    for (int k = 1; k <= 6; k++) begin
      if (busy_o[1]) busy_cnt++;
      if (k == 4) chk("l3_pc_hold", pc_o[1], 32'h3C);
      if (k == 5) chk("l3_pc_load", pc_o[1], 32'hC8);
      if (k == 6) chk("l3_cause_kept", 32'(cause_o[1]), 32'h3);
      pc_write = (k == 2 || k == 3); exc_divzero = (k == 2 || k == 3);
      tick();
    end
    clear_in();
    chk("l3_busy_len", busy_cnt, 32'd4);
    repeat (6) tick();
    exc_opcode = 1; tick(); exc_opcode = 0; tick();
    chk("wait_busy", 32'(busy_o[1]), 32'h1);
    #2 reset = 1; #1;
    chk("wait_rst_busy", 32'(busy_o[1]), 32'h0);
    chk("wait_rst_pc", pc_o[1], 32'h0);
    chk("wait_rst_epc", epc_o[1], 32'h0);
    tick(); reset = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("wait_rst_no_req", 32'(rdreq_o[1]), 32'h0);
    end
    for (int n = 0; n < 400; n++) begin
      reset = $urandom_range(0, 99) == 0;
      pc_next = $urandom & 32'hFFFF_FFFC;
      pc_write = $urandom_range(0, 3) == 0;
      pc_write_cond = $urandom_range(0, 1) == 0;
      branch_type = 2'($urandom);
      alu_zero = 1'($urandom); alu_gt = 1'($urandom);
      exc_opcode = $urandom_range(0, 15) == 0;
      exc_overflow = $urandom_range(0, 15) == 0;
      exc_divzero = $urandom_range(0, 15) == 0;
      mem_hi = 24'($urandom);
      tick();
    end
    reset = 0; clear_in();
    repeat (6) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
